tqvp_uart_rx_ctrl: RTL
======================

Name: tqvp_uart_rx_ctrl

Overview:
Receive-side controller for the UART receiver. It drains received bytes from the receiver's valid/read handshake into a small show-ahead FIFO and owns the baud-divider configuration register that the receiver consumes. It also gates RTS on FIFO fill level and generates the level, idle-timeout and overrun interrupt for the peripheral register interface.

Parameters:
PAYLOAD_BITS, 8, data bits per byte; must match the receiver.
COUNT_REG_LEN, 13, width of the baud divider.
FIFO_DEPTH, 4, FIFO entries; power of 2, at least 2.
DEFAULT_DIVIDER, 6667, reset value of the baud divider.
IRQ_LEVEL, 1, FIFO level at or above which the level interrupt asserts; range 1..FIFO_DEPTH.
RTS_LEVEL, 3, FIFO level at or above which RTS is forced high; range 1..FIFO_DEPTH.
TIMEOUT_BITS, 40, idle bit-periods before the timeout flag sets; at least 1.
DROP_ON_FULL, 0, full-FIFO policy: 1 = ack and discard the byte and set overrun; 0 = leave the byte held in the receiver.

Ports:
clk  in  1  system clock
resetn  in  1  reset
rx_valid  in  1  receiver has a byte
rx_data  in  PAYLOAD_BITS  receiver byte
rx_read  out  1  one-cycle ack to the receiver
rx_rts  in  1  receiver RTS (active low)
uart_rts  out  1  RTS to pin (active low)
baud_divider  out  COUNT_REG_LEN  divider driven to the receiver
cfg_wr  in  1  load cfg_divider
cfg_divider  in  COUNT_REG_LEN  new divider value
flush  in  1  clear FIFO and all flags
rd_en  in  1  pop the head entry
rd_data  out  PAYLOAD_BITS  head entry (show-ahead)
rd_avail  out  1  FIFO not empty
level  out  $clog2(FIFO_DEPTH)+1  current entry count
overrun  out  1  sticky overrun flag
clr_overrun  in  1  clear the overrun flag
timeout  out  1  sticky idle-timeout flag
irq_en  in  1  interrupt enable
irq  out  1  interrupt request

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (resetn). While resetn=0: FIFO empty, level=0, rd_avail=0, rx_read=0, overrun=0, timeout=0, irq=0, baud_divider=DEFAULT_DIVIDER, drain FSM=IDLE, and all internal counters cleared. rd_data is don't-care while empty. Asserting reset mid-transfer abandons the transfer without a push.
- Drain FSM, two states:
  - IDLE: when rx_valid=1 and the FIFO is not full, push rx_data on this edge, drive rx_read<=1, go to ACK.
  - IDLE, FIFO full, DROP_ON_FULL=1: drive rx_read<=1, set overrun, no push, go to ACK.
  - IDLE, FIFO full, DROP_ON_FULL=0: no action; the byte stays held in the receiver.
  - ACK: rx_read<=0, return to IDLE. rx_valid is ignored in ACK because it is still the stale byte.
  - rx_read is therefore high for exactly 1 cycle per byte. The next byte can be accepted no earlier than 2 cycles later.
- FIFO:
  - rd_data = mem[rd_ptr], combinational.
  - rd_en while empty is ignored.
  - Push and pop on the same edge leave level unchanged. When full this frees the slot and the push succeeds.
  - Pointers wrap modulo FIFO_DEPTH; level saturates 0..FIFO_DEPTH.
- flush: highest priority.
  - Empties the FIFO and clears overrun and timeout; a simultaneous push is discarded.
  - The drain FSM still completes any ACK in flight.
  - baud_divider is unaffected.
- overrun: set as described above, cleared by clr_overrun or flush. A set on the same edge as clr_overrun wins.
- baud_divider: loaded on cfg_wr and takes effect on the next cycle. Writing mid-byte is permitted and the result is undefined for that byte. A cfg_divider value of 0 is stored as-is.
- Timeout:
  - An internal COUNT_REG_LEN-bit cycle counter wraps when it reaches baud_divider, giving one bit tick.
  - A bit-period counter increments on each bit tick, saturating at TIMEOUT_BITS.
  - Both counters clear on push, pop, flush, or while the FIFO is empty.
  - timeout sets when the bit-period counter reaches TIMEOUT_BITS with the FIFO non-empty. It clears on pop or flush.
- uart_rts = rx_rts OR (level >= RTS_LEVEL). Registered; 1 at reset.
- irq = irq_en AND ((level >= IRQ_LEVEL) OR timeout OR overrun). Registered, so it follows its inputs by 1 cycle.

Test Plan:
- Single byte: rx_valid=1, rx_data=0xA5 -> rx_read high exactly 1 cycle, level=1, rd_avail=1, rd_data=0xA5; irq=1 one cycle later with irq_en=1.
- Fill to depth 4 with 0x01..0x04, DROP_ON_FULL=0 -> uart_rts=1 from level 3; a 5th byte with rx_valid held gets no rx_read. After one rd_en: 0x01 is popped, the 5th byte is acked on the next IDLE cycle, and read order is 0x02,0x03,0x04,0x05.
- DROP_ON_FULL=1, full FIFO, new byte 0x77 -> rx_read pulses, overrun=1, level stays 4, 0x77 never appears. Then clr_overrun -> overrun=0 on the next cycle.
- Timeout: baud_divider=10, push one byte, then idle -> timeout=1 after 40 bit-ticks (~440 cycles) and not before. rd_en -> timeout=0 and level=0.
- Push and pop on the same edge at level 2 -> level stays 2 and data order is preserved. flush with a simultaneous push -> level=0, overrun=0.
- resetn low during ACK and while holding 3 entries -> immediately level=0, rx_read=0, baud_divider=6667, uart_rts=1. cfg_wr with 0x0100 after release -> baud_divider=0x0100 on the next cycle.

Source files
------------

// File: rtl/tqvp_uart_rx_ctrl.sv
// Receive-side UART controller: drains receiver bytes into a show-ahead FIFO,
// holds the baud divider, gates RTS on fill level and raises level/timeout/overrun interrupts.
module tqvp_uart_rx_ctrl #(
    parameter int PAYLOAD_BITS    = 8,
    parameter int COUNT_REG_LEN   = 13,
    parameter int FIFO_DEPTH      = 4,
    parameter int DEFAULT_DIVIDER = 6667,
    parameter int IRQ_LEVEL       = 1,
    parameter int RTS_LEVEL       = 3,
    parameter int TIMEOUT_BITS    = 40,
    parameter bit DROP_ON_FULL    = 1'b0
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            rx_valid,
    input  logic [PAYLOAD_BITS-1:0]         rx_data,
    output logic                            rx_read,
    input  logic                            rx_rts,
    output logic                            uart_rts,
    output logic [COUNT_REG_LEN-1:0]        baud_divider,
    input  logic                            cfg_wr,
    input  logic [COUNT_REG_LEN-1:0]        cfg_divider,
    input  logic                            flush,
    input  logic                            rd_en,
    output logic [PAYLOAD_BITS-1:0]         rd_data,
    output logic                            rd_avail,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            overrun,
    input  logic                            clr_overrun,
    output logic                            timeout,
    input  logic                            irq_en,
    output logic                            irq,
    output logic                            dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TB_W  = $clog2(TIMEOUT_BITS + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] IRQ_LVL  = LVL_W'(IRQ_LEVEL);
    localparam logic [LVL_W-1:0] RTS_LVL  = LVL_W'(RTS_LEVEL);
    localparam logic [TB_W-1:0]  TO_MAX   = TB_W'(TIMEOUT_BITS);

    // Receiver handshake: rx_valid holds a byte until rx_read pulses for one cycle;
    // valid is still high (stale) during that ACK cycle, so it is ignored there.
    typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} drain_state_t;
    drain_state_t state, state_next;

    logic [PAYLOAD_BITS-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [LVL_W-1:0]         count;
    logic                     empty, full, pop, accept, drop, push;
    logic [COUNT_REG_LEN-1:0] cyc_cnt;
    logic [TB_W-1:0]          bit_cnt, bit_cnt_next;
    logic                     cnt_clear, bit_tick;

    assign empty = (count == '0);
    assign full  = (count == FULL_LVL);
    assign pop   = rd_en && !empty;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    // A same-edge pop frees the slot for the incoming byte.
                    if (!full || pop) begin
                        accept     = 1'b1;
                        state_next = S_ACK;
                    end else if (DROP_ON_FULL) begin
                        drop       = 1'b1;
                        state_next = S_ACK;
                    end
                end
            end
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign push = accept && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    assign rx_read   = (state == S_ACK);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign rd_data  = mem[rd_ptr];
    assign rd_avail = !empty;
    assign level    = count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)          overrun <= 1'b0;
        else if (flush)       overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (clr_overrun) overrun <= 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     baud_divider <= COUNT_REG_LEN'(DEFAULT_DIVIDER);
        else if (cfg_wr) baud_divider <= cfg_divider;
    end

    // Idle timer only runs while bytes sit untouched in the FIFO.
    assign cnt_clear = push || pop || flush || empty;
    assign bit_tick  = (cyc_cnt >= baud_divider);

    always_comb begin
        bit_cnt_next = bit_cnt;
        if (cnt_clear)                        bit_cnt_next = '0;
        else if (bit_tick && bit_cnt != TO_MAX) bit_cnt_next = bit_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt_next;
            if (cnt_clear || bit_tick) cyc_cnt <= '0;
            else                       cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                      timeout <= 1'b0;
        else if (flush || pop)            timeout <= 1'b0;
        else if (bit_cnt_next == TO_MAX)  timeout <= 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_rts <= 1'b1;
            irq      <= 1'b0;
        end else begin
            uart_rts <= rx_rts || (count >= RTS_LVL);
            irq      <= irq_en && ((count >= IRQ_LVL) || timeout || overrun);
        end
    end

endmodule
